// File: rtl/sobel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sobel_ctrl_pkg
//  Shared definitions for the Sobel frame controller:
//   - register byte offsets of the control/status block
//   - CTRL and STATUS bit positions
//   - frame sequencer state encoding
// -----------------------------------------------------------------------------
package sobel_ctrl_pkg;

   // Register byte offsets
   localparam int unsigned REG_CTRL        = 32'h00;
   localparam int unsigned REG_FRAME_WORDS = 32'h04;
   localparam int unsigned REG_STATUS      = 32'h08;
   localparam int unsigned REG_BEAT_COUNT  = 32'h0C;

   // CTRL bits
   localparam int CTRL_START   = 0;  // self-clearing, reads 0
   localparam int CTRL_FILTER  = 1;
   localparam int CTRL_INTR_EN = 2;
   localparam int CTRL_ABORT   = 3;  // self-clearing, reads 0

   // STATUS bits
   localparam int STAT_BUSY = 0;     // read-only
   localparam int STAT_DONE = 1;     // write-1-to-clear
   localparam int STAT_ERR  = 2;     // write-1-to-clear

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_INTR = 2'd2
   } state_t;

endpackage

// File: rtl/sobel_ctrl_regs.sv
// -----------------------------------------------------------------------------
// sobel_ctrl_regs
//  Control/status register file of the Sobel frame controller.
//  Decodes register writes, keeps CTRL/FRAME_WORDS/STATUS state, produces the
//  START/ABORT command pulses and returns registered read data.
// Ports
//  i_clk, i_rst_n     clock, asynchronous active-low reset
//  i_reg_addr         register byte offset
//  i_reg_data         write data
//  i_reg_wr_req       one-cycle write strobe
//  i_reg_rd_req       one-cycle read strobe
//  o_reg_data         read data, valid with o_reg_rd_ack
//  o_reg_rd_ack       read acknowledge, one cycle after i_reg_rd_req
//  i_busy             STATUS.BUSY source (sequencer running)
//  i_beat_count       BEAT_COUNT source
//  i_set_done         sets STATUS.DONE
//  i_set_err          sets STATUS.ERR
//  o_start            START command pulse (CTRL write with bit 0 set)
//  o_abort            ABORT command pulse (CTRL write with bit 3 set)
//  o_filter           CTRL.FILTER
//  o_intr_en          CTRL.INTR_EN
//  o_frame_words      FRAME_WORDS register
// -----------------------------------------------------------------------------
module sobel_ctrl_regs
   import sobel_ctrl_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_reg_addr,
   input  logic [DATA_W-1:0] i_reg_data,
   input  logic              i_reg_wr_req,
   input  logic              i_reg_rd_req,
   output logic [DATA_W-1:0] o_reg_data,
   output logic              o_reg_rd_ack,
   input  logic              i_busy,
   input  logic [DATA_W-1:0] i_beat_count,
   input  logic              i_set_done,
   input  logic              i_set_err,
   output logic              o_start,
   output logic              o_abort,
   output logic              o_filter,
   output logic              o_intr_en,
   output logic [DATA_W-1:0] o_frame_words
);

   logic              sel_ctrl;
   logic              sel_fw;
   logic              sel_status;
   logic              sel_beat;
   logic              wr_ctrl;
   logic              wr_fw;
   logic              wr_status;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] rd_mux;

   assign sel_ctrl   = (i_reg_addr == ADDR_W'(REG_CTRL));
   assign sel_fw     = (i_reg_addr == ADDR_W'(REG_FRAME_WORDS));
   assign sel_status = (i_reg_addr == ADDR_W'(REG_STATUS));
   assign sel_beat   = (i_reg_addr == ADDR_W'(REG_BEAT_COUNT));

   assign wr_ctrl   = i_reg_wr_req & sel_ctrl;
   assign wr_fw     = i_reg_wr_req & sel_fw;
   assign wr_status = i_reg_wr_req & sel_status;

   // START and ABORT are never stored: they act as pulses in the write cycle.
   assign o_start = wr_ctrl & i_reg_data[CTRL_START];
   assign o_abort = wr_ctrl & i_reg_data[CTRL_ABORT];

   // NOTE: state is updated with non-blocking (<=) so every flop samples the
   // pre-edge values and the result does not depend on process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_filter      <= 1'b0;
         o_intr_en     <= 1'b0;
         o_frame_words <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            o_filter  <= i_reg_data[CTRL_FILTER];
            o_intr_en <= i_reg_data[CTRL_INTR_EN];
         end
         if (wr_fw) begin
            o_frame_words <= i_reg_data;
         end
         // The set term is OR-ed after the W1C mask, so a same-cycle set wins.
         done <= (done & ~(wr_status & i_reg_data[STAT_DONE])) | i_set_done;
         err  <= (err  & ~(wr_status & i_reg_data[STAT_ERR]))  | i_set_err;
      end
   end

   // NOTE: rd_mux gets a default before any branch, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      rd_mux = '0;
      if (sel_ctrl) begin
         rd_mux[CTRL_FILTER]  = o_filter;
         rd_mux[CTRL_INTR_EN] = o_intr_en;
      end else if (sel_fw) begin
         rd_mux = o_frame_words;
      end else if (sel_status) begin
         rd_mux[STAT_BUSY] = i_busy;
         rd_mux[STAT_DONE] = done;
         rd_mux[STAT_ERR]  = err;
      end else if (sel_beat) begin
         rd_mux = i_beat_count;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_reg_rd_ack <= 1'b0;
         o_reg_data   <= '0;
      end else begin
         o_reg_rd_ack <= i_reg_rd_req;
         if (i_reg_rd_req) begin
            o_reg_data <= rd_mux;
         end
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//  Frame-level sequencer between the PCIe stream ports and the Sobel filter
//  core. Gates the three line-input handshakes and the result handshake while
//  a frame is running, counts result beats and raises the frame-done interrupt.
//  Data buses bypass this block; only valid/ack pass through it.
// Ports
//  i_clk, i_rst_n        clock, asynchronous active-low reset
//  i_reg_*/o_reg_*       register access (see sobel_ctrl_regs)
//  i_pcie_line_valid     line 1..3 valids from PCIe
//  o_pcie_line_ack       line acks back to PCIe (gated)
//  o_core_line_valid     line valids to the core (gated)
//  i_core_line_ack       line acks from the core
//  i_core_res_valid      result valid from the core
//  o_core_res_ack        result ack to the core (gated)
//  o_pcie_res_valid      result valid to PCIe (gated)
//  i_pcie_res_ack        result ack from PCIe
//  o_filter              filter enable to the core
//  o_intr_req            frame-done interrupt request (registered)
//  i_intr_ack            interrupt acknowledge
// -----------------------------------------------------------------------------
module sobel_frame_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_reg_addr,
   input  logic [DATA_W-1:0] i_reg_data,
   input  logic              i_reg_wr_req,
   input  logic              i_reg_rd_req,
   output logic [DATA_W-1:0] o_reg_data,
   output logic              o_reg_rd_ack,
   input  logic [2:0]        i_pcie_line_valid,
   output logic [2:0]        o_pcie_line_ack,
   output logic [2:0]        o_core_line_valid,
   input  logic [2:0]        i_core_line_ack,
   input  logic              i_core_res_valid,
   output logic              o_core_res_ack,
   output logic              o_pcie_res_valid,
   input  logic              i_pcie_res_ack,
   output logic              o_filter,
   output logic              o_intr_req,
   input  logic              i_intr_ack
);

   state_t            state;
   state_t            state_nxt;
   logic              run;
   logic              beat;
   logic              last_beat;
   logic              start;
   logic              abort;
   logic              intr_en;
   logic [DATA_W-1:0] frame_words;
   logic [CNT_W-1:0]  beat_count;
   logic [CNT_W-1:0]  frame_words_q;
   logic              set_done;
   logic              set_err;
   logic              cnt_clear;
   logic              cnt_inc;

   sobel_ctrl_regs #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_regs (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_reg_addr    (i_reg_addr),
      .i_reg_data    (i_reg_data),
      .i_reg_wr_req  (i_reg_wr_req),
      .i_reg_rd_req  (i_reg_rd_req),
      .o_reg_data    (o_reg_data),
      .o_reg_rd_ack  (o_reg_rd_ack),
      .i_busy        (run),
      .i_beat_count  (DATA_W'(beat_count)),
      .i_set_done    (set_done),
      .i_set_err     (set_err),
      .o_start       (start),
      .o_abort       (abort),
      .o_filter      (o_filter),
      .o_intr_en     (intr_en),
      .o_frame_words (frame_words)
   );

   // Handshake gating: everything is closed unless a frame is running.
   assign run               = (state == ST_RUN);
   assign o_core_line_valid = i_pcie_line_valid & {3{run}};
   assign o_pcie_line_ack   = i_core_line_ack & {3{run}};
   assign o_pcie_res_valid  = i_core_res_valid & run;
   assign o_core_res_ack    = i_pcie_res_ack & run;
   assign beat              = o_pcie_res_valid & i_pcie_res_ack;

   // Compared against the copy latched at START, so FRAME_WORDS writes made
   // during a frame only apply to the next one.
   assign last_beat = (beat_count == frame_words_q - CNT_W'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         o_intr_req <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_intr_req <= (state_nxt == ST_INTR);
      end
   end

   always_comb begin
      state_nxt = state;
      set_done  = 1'b0;
      set_err   = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (frame_words != '0) begin
                  cnt_clear = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         ST_RUN: begin
            cnt_inc = beat;
            if (start) begin
               set_err = 1'b1;
            end
            // ABORT takes priority over a coincident final beat; the beat
            // itself is still counted.
            if (abort) begin
               set_err   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (beat && last_beat) begin
               set_done  = 1'b1;
               state_nxt = intr_en ? ST_INTR : ST_IDLE;
            end
         end
         ST_INTR: begin
            if (start) begin
               set_err = 1'b1;
            end
            if (i_intr_ack) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beat_count    <= '0;
         frame_words_q <= '0;
      end else if (cnt_clear) begin
         beat_count    <= '0;
         frame_words_q <= CNT_W'(frame_words);
      end else if (cnt_inc) begin
         beat_count <= beat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//  Directed bench for sobel_frame_ctrl. Register reads push their expected
//  value into a scoreboard; a monitor pops and compares on every o_reg_rd_ack.
//  Gating and interrupt outputs are compared directly against constants.
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

   localparam logic [19:0] A_CTRL   = 20'h00;
   localparam logic [19:0] A_FW     = 20'h04;
   localparam logic [19:0] A_STATUS = 20'h08;
   localparam logic [19:0] A_BEAT   = 20'h0C;
   localparam logic [19:0] A_UNMAP  = 20'h10;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [19:0] i_reg_addr = '0;
   logic [31:0] i_reg_data = '0;
   logic        i_reg_wr_req = 1'b0;
   logic        i_reg_rd_req = 1'b0;
   logic [31:0] o_reg_data;
   logic        o_reg_rd_ack;
   logic [2:0]  i_pcie_line_valid = '0;
   logic [2:0]  o_pcie_line_ack;
   logic [2:0]  o_core_line_valid;
   logic [2:0]  i_core_line_ack = '0;
   logic        i_core_res_valid = 1'b0;
   logic        o_core_res_ack;
   logic        o_pcie_res_valid;
   logic        i_pcie_res_ack = 1'b0;
   logic        o_filter;
   logic        o_intr_req;
   logic        i_intr_ack = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   string       name_q[$];
   logic [31:0] exp_q[$];
   string       mon_name;
   logic [31:0] mon_exp;

   always #5 i_clk = ~i_clk;

   sobel_frame_ctrl dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_reg_addr        (i_reg_addr),
      .i_reg_data        (i_reg_data),
      .i_reg_wr_req      (i_reg_wr_req),
      .i_reg_rd_req      (i_reg_rd_req),
      .o_reg_data        (o_reg_data),
      .o_reg_rd_ack      (o_reg_rd_ack),
      .i_pcie_line_valid (i_pcie_line_valid),
      .o_pcie_line_ack   (o_pcie_line_ack),
      .o_core_line_valid (o_core_line_valid),
      .i_core_line_ack   (i_core_line_ack),
      .i_core_res_valid  (i_core_res_valid),
      .o_core_res_ack    (o_core_res_ack),
      .o_pcie_res_valid  (o_pcie_res_valid),
      .i_pcie_res_ack    (i_pcie_res_ack),
      .o_filter          (o_filter),
      .o_intr_req        (o_intr_req),
      .i_intr_ack        (i_intr_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read acknowledge consumes one expected entry.
   always @(negedge i_clk) begin
      if (o_reg_rd_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_ack_unexpected: got ack with data 0x%0h, expected no ack", o_reg_data);
         end else begin
            mon_name = name_q.pop_front();
            mon_exp  = exp_q.pop_front();
            check(mon_name, o_reg_data, mon_exp);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic reg_write(input logic [19:0] addr, input logic [31:0] data);
      i_reg_addr   = addr;
      i_reg_data   = data;
      i_reg_wr_req = 1'b1;
      tick();
      i_reg_wr_req = 1'b0;
   endtask

   task automatic reg_read(input string name, input logic [19:0] addr, input logic [31:0] exp);
      name_q.push_back(name);
      exp_q.push_back(exp);
      i_reg_addr   = addr;
      i_reg_rd_req = 1'b1;
      tick();
      i_reg_rd_req = 1'b0;
      tick();
   endtask

   task automatic beat();
      i_core_res_valid = 1'b1;
      i_pcie_res_ack   = 1'b1;
      tick();
      i_core_res_valid = 1'b0;
      i_pcie_res_ack   = 1'b0;
   endtask

   // A register write and a result beat landing on the same clock edge.
   task automatic reg_write_beat(input logic [19:0] addr, input logic [31:0] data);
      i_core_res_valid = 1'b1;
      i_pcie_res_ack   = 1'b1;
      reg_write(addr, data);
      i_core_res_valid = 1'b0;
      i_pcie_res_ack   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_intr", {31'd0, o_intr_req}, 32'd0);
      check("rst_filter", {31'd0, o_filter}, 32'd0);
      check("rst_rd_ack", {31'd0, o_reg_rd_ack}, 32'd0);
      check("rst_rd_data", o_reg_data, 32'd0);
      i_rst_n = 1'b1;
      tick();
      reg_read("rst_ctrl", A_CTRL, 32'h0);
      reg_read("rst_fw", A_FW, 32'h0);
      reg_read("rst_status", A_STATUS, 32'h0);
      reg_read("rst_beat", A_BEAT, 32'h0);

      // T2: handshakes closed in IDLE
      i_pcie_line_valid = 3'b111;
      i_core_line_ack   = 3'b111;
      i_core_res_valid  = 1'b1;
      i_pcie_res_ack    = 1'b1;
      #1;
      check("t2_core_line_valid", {29'd0, o_core_line_valid}, 32'd0);
      check("t2_pcie_line_ack", {29'd0, o_pcie_line_ack}, 32'd0);
      check("t2_pcie_res_valid", {31'd0, o_pcie_res_valid}, 32'd0);
      check("t2_core_res_ack", {31'd0, o_core_res_ack}, 32'd0);
      tick();
      i_pcie_line_valid = '0;
      i_core_line_ack   = '0;
      i_core_res_valid  = 1'b0;
      i_pcie_res_ack    = 1'b0;
      reg_read("t2_beat", A_BEAT, 32'h0);

      // Unmapped address: write ignored, reads 0
      reg_write(A_UNMAP, 32'hFFFF_FFFF);
      reg_read("unmapped", A_UNMAP, 32'h0);

      // T3: START with FRAME_WORDS == 0
      reg_write(A_FW, 32'd0);
      reg_write(A_CTRL, 32'h1);
      reg_read("t3_status", A_STATUS, 32'h4);
      i_core_res_valid = 1'b1;
      #1;
      check("t3_gate_closed", {31'd0, o_pcie_res_valid}, 32'd0);
      i_core_res_valid = 1'b0;
      reg_write(A_STATUS, 32'h4);
      reg_read("t3_err_cleared", A_STATUS, 32'h0);

      // T1: full frame with interrupt
      reg_write(A_FW, 32'd4);
      reg_write(A_CTRL, 32'h7);
      check("t1_filter", {31'd0, o_filter}, 32'd1);
      reg_read("t1_status_busy", A_STATUS, 32'h1);
      reg_read("t1_ctrl", A_CTRL, 32'h6);
      i_pcie_line_valid = 3'b101;
      i_core_line_ack   = 3'b011;
      i_core_res_valid  = 1'b1;
      #1;
      check("t1_core_line_valid", {29'd0, o_core_line_valid}, 32'h5);
      check("t1_pcie_line_ack", {29'd0, o_pcie_line_ack}, 32'h3);
      check("t1_pcie_res_valid", {31'd0, o_pcie_res_valid}, 32'd1);
      i_pcie_line_valid = '0;
      i_core_line_ack   = '0;
      i_core_res_valid  = 1'b0;
      repeat (3) beat();
      check("t1_intr_before_last", {31'd0, o_intr_req}, 32'd0);
      beat();
      check("t1_intr_after_last", {31'd0, o_intr_req}, 32'd1);
      reg_read("t1_status_done", A_STATUS, 32'h2);
      reg_read("t1_beat", A_BEAT, 32'd4);
      reg_write(A_CTRL, 32'h7);
      reg_read("t1_start_in_intr", A_STATUS, 32'h6);
      i_intr_ack = 1'b1;
      #1;
      check("t1_intr_held", {31'd0, o_intr_req}, 32'd1);
      tick();
      i_intr_ack = 1'b0;
      check("t1_intr_dropped", {31'd0, o_intr_req}, 32'd0);
      i_core_res_valid = 1'b1;
      #1;
      check("t1_gate_closed", {31'd0, o_pcie_res_valid}, 32'd0);
      i_core_res_valid = 1'b0;
      reg_write(A_STATUS, 32'h6);
      reg_read("t1_status_cleared", A_STATUS, 32'h0);

      // T4: START while running, then ABORT after two beats
      reg_write(A_FW, 32'd8);
      reg_write(A_CTRL, 32'h3);
      beat();
      beat();
      reg_write(A_CTRL, 32'h3);
      reg_read("t4_start_in_run", A_STATUS, 32'h5);
      reg_write(A_CTRL, 32'hA);
      reg_read("t4_status", A_STATUS, 32'h4);
      reg_read("t4_beat", A_BEAT, 32'd2);
      check("t4_no_intr", {31'd0, o_intr_req}, 32'd0);
      reg_write(A_STATUS, 32'h4);

      // ABORT coincident with the final beat: beat counts, ABORT wins
      reg_write(A_FW, 32'd1);
      reg_write(A_CTRL, 32'h1);
      reg_write_beat(A_CTRL, 32'h8);
      reg_read("abort_last_status", A_STATUS, 32'h4);
      reg_read("abort_last_beat", A_BEAT, 32'd1);
      reg_write(A_STATUS, 32'h4);

      // T6: frame without interrupt, DONE cleared by W1C
      reg_write(A_FW, 32'd1);
      reg_write(A_CTRL, 32'h1);
      beat();
      check("t6_no_intr", {31'd0, o_intr_req}, 32'd0);
      reg_read("t6_status_done", A_STATUS, 32'h2);
      reg_write(A_STATUS, 32'h2);
      reg_read("t6_status_cleared", A_STATUS, 32'h0);

      // DONE set and W1C in the same cycle: set wins
      reg_write(A_CTRL, 32'h1);
      reg_write_beat(A_STATUS, 32'h2);
      reg_read("w1c_vs_set", A_STATUS, 32'h2);
      reg_write(A_STATUS, 32'h2);

      // FRAME_WORDS rewritten mid-frame applies only to the next frame
      reg_write(A_FW, 32'd2);
      reg_write(A_CTRL, 32'h1);
      reg_write(A_FW, 32'd1);
      beat();
      reg_read("fw_latched_busy", A_STATUS, 32'h1);
      beat();
      reg_read("fw_latched_done", A_STATUS, 32'h2);
      reg_read("fw_latched_beat", A_BEAT, 32'd2);
      reg_write(A_STATUS, 32'h2);

      // T5: asynchronous reset with the interrupt pending
      reg_write(A_FW, 32'd1);
      reg_write(A_CTRL, 32'h7);
      beat();
      check("t5_intr_pending", {31'd0, o_intr_req}, 32'd1);
      name_q.push_back("t5_ctrl_before_rst");
      exp_q.push_back(32'h6);
      i_reg_addr   = A_CTRL;
      i_reg_rd_req = 1'b1;
      tick();
      i_reg_rd_req      = 1'b0;
      i_pcie_line_valid = 3'b111;
      i_core_line_ack   = 3'b111;
      i_core_res_valid  = 1'b1;
      i_pcie_res_ack    = 1'b1;
      @(negedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      check("t5_intr", {31'd0, o_intr_req}, 32'd0);
      check("t5_filter", {31'd0, o_filter}, 32'd0);
      check("t5_rd_ack", {31'd0, o_reg_rd_ack}, 32'd0);
      check("t5_rd_data", o_reg_data, 32'd0);
      check("t5_core_line_valid", {29'd0, o_core_line_valid}, 32'd0);
      check("t5_pcie_line_ack", {29'd0, o_pcie_line_ack}, 32'd0);
      check("t5_pcie_res_valid", {31'd0, o_pcie_res_valid}, 32'd0);
      check("t5_core_res_ack", {31'd0, o_core_res_ack}, 32'd0);
      i_pcie_line_valid = '0;
      i_core_line_ack   = '0;
      i_core_res_valid  = 1'b0;
      i_pcie_res_ack    = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
      reg_read("t5_status_after", A_STATUS, 32'h0);
      reg_read("t5_beat_after", A_BEAT, 32'h0);
      reg_read("t5_fw_after", A_FW, 32'h0);

      // Every issued read must have been acknowledged.
      repeat (4) tick();
      check("sb_drain", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
